log_energy_pipe: RTL

Streaming, pipelined fixed-point energy-to-dB converter for the MFCC datapath. It replaces the integer-only 6·floor(log2) lookup with a fractional log2 that uses a mantissa LUT. It adds a selectable 20·log10 (amplitude) or 10·log10 (power) scale and a valid/ready handshake, so it sits between the mel filterbank accumulator and the DCT stage.

---
 rtl/mfcc_log_pkg.sv | 46 ++++
 rtl/lead_one_detect.sv | 24 ++
 rtl/log_energy_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/mfcc_log_pkg.sv
// Shared definitions for the MFCC log-energy stage.
//   SCALE_20LOG / SCALE_10LOG : dB-per-octave multipliers, Q0.8
//   lut_t / gen_mant_lut      : mantissa log2 table, Q0.8, up to 8 index bits
//   stage_t                   : stage-1 payload (k, m, mode, zero)
package mfcc_log_pkg;

  localparam int SCALE_20LOG = 1541;  // 20*log10(2) * 256
  localparam int SCALE_10LOG = 771;   // 10*log10(2) * 256
  localparam int LUT_DEPTH   = 256;
  localparam int LUT_W       = 9;
  localparam int K_W         = 8;
  localparam int M_W         = 8;

  typedef logic [LUT_DEPTH-1:0][LUT_W-1:0] lut_t;

  typedef struct packed {
    logic [K_W-1:0] k;
    logic [M_W-1:0] m;
    logic           mode;
    logic           zero;
  } stage_t;

  // round(256*log2(1 + m/2^frac_bits)) with integers only: repeated squaring
  // of a Q1.30 value yields 9 fractional bits of log2, then round-half-up.
  function automatic lut_t gen_mant_lut(input int frac_bits);
    lut_t        lut;
    logic [63:0] y;
    int          f;
    lut = '0;
    for (int m = 0; m < (1 << frac_bits); m++) begin
      y = (64'(m) + (64'd1 << frac_bits)) << (30 - frac_bits);
      f = 0;
      for (int b = 0; b < 9; b++) begin
        y = (y * y) >> 30;
        f = f << 1;
        if (y >= (64'd2 << 30)) begin
          f = f | 1;
          y = y >> 1;
        end
      end
      lut[m] = LUT_W'((f + 1) >> 1);
    end
    return lut;
  endfunction

endpackage

// File: rtl/lead_one_detect.sv
// Combinational leading-one detector.
//   i_num  : input word
//   o_idx  : index of highest set bit (0 when i_num == 0)
//   o_zero : i_num == 0
module lead_one_detect #(
  parameter int W = 32
) (
  input  logic [W-1:0]         i_num,
  output logic [$clog2(W)-1:0] o_idx,
  output logic                 o_zero
);

  localparam int IW = $clog2(W);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < W; i++)
      if (i_num[i]) o_idx = IW'(i);
  end

  assign o_zero = (i_num == '0);

endmodule

// File: rtl/log_energy_pipe.sv
// Streaming fixed-point energy-to-dB converter, 3-stage pipeline, global stall.
//   clk, rst_n          : clock, async active-low reset
//   valid_i / ready_o   : input handshake; number_i, mode_i sampled on transfer
//   valid_o / ready_i   : output handshake; log_o (Q.OUT_FRAC dB), zero_o
// Stage 1: leading-one detect + mantissa, stage 2: log2 in Q.8,
// stage 3: scale by dB/octave, round half-up, saturate.
module log_energy_pipe
  import mfcc_log_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int FRAC_BITS = 4,
  parameter int OUT_W     = 10,
  parameter int OUT_FRAC  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  number_i,
  input  logic             mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] log_o,
  output logic             zero_o
);

  localparam int   KW     = $clog2(IN_W);
  localparam int   LW     = KW + 8;
  localparam int   STAGES = 3;
  localparam lut_t LUT    = gen_mant_lut(FRAC_BITS);

  logic [STAGES:1]      r_vld_pipe;
  logic                 w_adv;

  logic [KW-1:0]        w_idx;
  logic                 w_zero;
  logic [KW-1:0]        w_shamt;
  logic [IN_W-1:0]      w_norm;
  logic [IN_W+FRAC_BITS-1:0] w_ext;
  logic [FRAC_BITS-1:0] w_m;
  stage_t               w_s1, r_s1;

  logic [LW-1:0]        w_l, r_l;
  logic                 r_mode2, r_zero2;

  logic [39:0]          w_p, w_r;
  logic                 w_sat;
  logic [OUT_W-1:0]     w_log, r_log;
  logic                 r_zero;

  assign w_adv   = !r_vld_pipe[STAGES] || ready_i;
  assign ready_o = w_adv;
  assign valid_o = r_vld_pipe[STAGES];
  assign log_o   = r_log;
  assign zero_o  = r_zero;

  // Stage 1: shift the leading one to the MSB, then take the bits below it;
  // the zero tail appended on the right covers k < FRAC_BITS.
  lead_one_detect #(.W(IN_W)) u_lod (
    .i_num  (number_i),
    .o_idx  (w_idx),
    .o_zero (w_zero)
  );

  assign w_shamt = KW'(IN_W - 1) - w_idx;
  assign w_norm  = number_i << w_shamt;
  assign w_ext   = {w_norm, {FRAC_BITS{1'b0}}};
  assign w_m     = FRAC_BITS'(w_ext >> (IN_W - 1));
  assign w_s1    = '{k: K_W'(w_idx), m: M_W'(w_m), mode: mode_i, zero: w_zero};

  // Stage 2: integer part k in the upper bits, table fraction below.
  assign w_l = LW'({r_s1.k, 8'd0}) + LW'(LUT[r_s1.m]);

  // Stage 3: Q.8 * Q0.8 = Q.16, rounded down to OUT_FRAC bits.
  assign w_p   = 40'(r_l) * 40'(r_mode2 ? SCALE_10LOG : SCALE_20LOG);
  assign w_r   = (w_p + (40'd1 << (15 - OUT_FRAC))) >> (16 - OUT_FRAC);
  assign w_sat = w_r > 40'((64'd1 << OUT_W) - 1);
  assign w_log = r_zero2 ? '0 : (w_sat ? '1 : OUT_W'(w_r));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
      r_l        <= '0;
      r_mode2    <= 1'b0;
      r_zero2    <= 1'b0;
      r_log      <= '0;
      r_zero     <= 1'b0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], valid_i};
      r_s1       <= w_s1;
      r_l        <= w_l;
      r_mode2    <= r_s1.mode;
      r_zero2    <= r_s1.zero;
      r_log      <= w_log;
      r_zero     <= r_zero2;
    end
  end

endmodule
